// File: rtl/nco_multi.sv
// rtl/nco_multi.sv - multi-channel round-robin NCO with shared byte-masked sine/cosine LUT
module nco_multi #(
    parameter int NCH     = 4,
    parameter int PHASE_W = 16,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int DELTA_W = 8,
    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int NB     = DATA_W / 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                csb0,
    input  logic                web0,
    input  logic [NB-1:0]       wmask0,
    input  logic [ADDR_W-1:0]   addr0,
    input  logic [DATA_W-1:0]   din00,
    input  logic [DATA_W-1:0]   din01,
    input  logic                csb1,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [DELTA_W-1:0]  cfg_delta,
    input  logic                cfg_up_dn,
    input  logic                cfg_preload,
    input  logic [PHASE_W-1:0]  cfg_pl_data,
    output logic                out_valid,
    output logic [CH_W-1:0]     out_ch,
    output logic [PHASE_W-1:0]  phase_out,
    output logic [DATA_W-1:0]   sine_out,
    output logic [DATA_W-1:0]   cosine_out
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0]  sin_mem [DEPTH];
    logic [DATA_W-1:0]  cos_mem [DEPTH];

    logic [PHASE_W-1:0] acc_q [NCH];
    logic [PHASE_W-1:0] acc_d [NCH];
    logic [DELTA_W-1:0] delta_q [NCH];
    logic [DELTA_W-1:0] delta_d [NCH];
    logic [NCH-1:0]     up_dn_q, up_dn_d;
    logic [CH_W-1:0]    ptr_q, ptr_d;

    logic               s1_valid_q, s1_valid_d;
    logic [CH_W-1:0]    s1_ch_q, s1_ch_d;
    logic [PHASE_W-1:0] s1_phase_q, s1_phase_d;
    logic [ADDR_W-1:0]  s1_addr_q, s1_addr_d;

    logic               s2_valid_q, s2_valid_d;
    logic [CH_W-1:0]    s2_ch_q, s2_ch_d;
    logic [PHASE_W-1:0] s2_phase_q, s2_phase_d;
    logic [DATA_W-1:0]  s2_sin_q, s2_sin_d;
    logic [DATA_W-1:0]  s2_cos_q, s2_cos_d;

    logic               out_valid_q, out_valid_d;
    logic [CH_W-1:0]    out_ch_q, out_ch_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [DATA_W-1:0]  sine_q, sine_d;
    logic [DATA_W-1:0]  cosine_q, cosine_d;

    logic run;
    logic cfg_hit;

    assign run     = !csb1;
    assign cfg_hit = cfg_we && ({1'b0, cfg_ch} < (CH_W + 1)'(NCH));

    // LUT contents are deliberately left out of reset
    always_ff @(posedge clk) begin
        if (!csb0 && !web0) begin
            for (int b = 0; b < NB; b++) begin
                if (wmask0[b]) begin
                    sin_mem[addr0][b*8 +: 8] <= din00[b*8 +: 8];
                    cos_mem[addr0][b*8 +: 8] <= din01[b*8 +: 8];
                end
            end
        end
    end

    // Preload is applied after accumulation so it wins a same-edge collision
    always_comb begin
        up_dn_d = up_dn_q;
        ptr_d   = ptr_q;
        for (int i = 0; i < NCH; i++) begin
            acc_d[i]   = acc_q[i];
            delta_d[i] = delta_q[i];
            if (run && ptr_q == CH_W'(i)) begin
                acc_d[i] = up_dn_q[i] ? acc_q[i] + PHASE_W'(delta_q[i])
                                      : acc_q[i] - PHASE_W'(delta_q[i]);
            end
            if (cfg_hit && cfg_ch == CH_W'(i)) begin
                delta_d[i] = cfg_delta;
                up_dn_d[i] = cfg_up_dn;
                if (cfg_preload) begin
                    acc_d[i] = cfg_pl_data;
                end
            end
        end
        if (run) begin
            ptr_d = (ptr_q == CH_W'(NCH - 1)) ? '0 : ptr_q + CH_W'(1);
        end
    end

    always_comb begin
        s1_valid_d = run;
        s1_ch_d    = s1_ch_q;
        s1_phase_d = s1_phase_q;
        s1_addr_d  = s1_addr_q;
        if (run) begin
            s1_ch_d    = ptr_q;
            s1_phase_d = acc_q[ptr_q];
            s1_addr_d  = acc_q[ptr_q][PHASE_W-1 -: ADDR_W];
        end
        s2_valid_d = s1_valid_q;
        s2_ch_d    = s1_ch_q;
        s2_phase_d = s1_phase_q;
        s2_sin_d   = sin_mem[s1_addr_q];
        s2_cos_d   = cos_mem[s1_addr_q];
        out_valid_d = s2_valid_q;
        out_ch_d    = out_ch_q;
        phase_d     = phase_q;
        sine_d      = sine_q;
        cosine_d    = cosine_q;
        if (s2_valid_q) begin
            out_ch_d = s2_ch_q;
            phase_d  = s2_phase_q;
            sine_d   = s2_sin_q;
            cosine_d = s2_cos_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                acc_q[i]   <= '0;
                delta_q[i] <= DELTA_W'(1);
            end
            up_dn_q     <= '1;
            ptr_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_ch_q     <= '0;
            s1_phase_q  <= '0;
            s1_addr_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_ch_q     <= '0;
            s2_phase_q  <= '0;
            s2_sin_q    <= '0;
            s2_cos_q    <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            phase_q     <= '0;
            sine_q      <= '0;
            cosine_q    <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                acc_q[i]   <= acc_d[i];
                delta_q[i] <= delta_d[i];
            end
            up_dn_q     <= up_dn_d;
            ptr_q       <= ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_ch_q     <= s1_ch_d;
            s1_phase_q  <= s1_phase_d;
            s1_addr_q   <= s1_addr_d;
            s2_valid_q  <= s2_valid_d;
            s2_ch_q     <= s2_ch_d;
            s2_phase_q  <= s2_phase_d;
            s2_sin_q    <= s2_sin_d;
            s2_cos_q    <= s2_cos_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            phase_q     <= phase_d;
            sine_q      <= sine_d;
            cosine_q    <= cosine_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_ch     = out_ch_q;
    assign phase_out  = phase_q;
    assign sine_out   = sine_q;
    assign cosine_out = cosine_q;
endmodule

// File: tb/tb_nco_multi.sv
// tb/tb_nco_multi.sv - self-checking bench for nco_multi against a sample-queue reference model
module tb_nco_multi;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        csb0 = 1'b1;
    logic        web0 = 1'b1;
    logic [3:0]  wmask0 = '0;
    logic [7:0]  addr0 = '0;
    logic [31:0] din00 = '0;
    logic [31:0] din01 = '0;
    logic        csb1 = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [7:0]  cfg_delta = '0;
    logic        cfg_up_dn = 1'b1;
    logic        cfg_preload = 1'b0;
    logic [15:0] cfg_pl_data = '0;
    logic        out_valid;
    logic [1:0]  out_ch;
    logic [15:0] phase_out;
    logic [31:0] sine_out;
    logic [31:0] cosine_out;

    always #5 clk = ~clk;

    nco_multi dut (
        .clk(clk), .reset_n(reset_n),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
        .din00(din00), .din01(din01), .csb1(csb1),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_delta(cfg_delta),
        .cfg_up_dn(cfg_up_dn), .cfg_preload(cfg_preload), .cfg_pl_data(cfg_pl_data),
        .out_valid(out_valid), .out_ch(out_ch), .phase_out(phase_out),
        .sine_out(sine_out), .cosine_out(cosine_out)
    );

    typedef struct {
        int          due;
        int          ch;
        logic [15:0] ph;
        logic [31:0] s;
        logic [31:0] c;
    } smp_t;

    logic [31:0] msin [256];
    logic [31:0] mcos [256];
    logic [15:0] macc [4];
    logic [7:0]  mdel [4];
    logic        mup  [4];
    int          mptr;
    int          cyc;
    smp_t        q[$];
    logic [31:0] last_s, last_c;
    logic [15:0] last_ph;
    int          last_ch;
    bit          t2_on;
    int          ncnt [4];
    int          passed = 0;
    int          total = 0;
    int          fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            macc[k] = '0;
            mdel[k] = 8'd1;
            mup[k]  = 1'b1;
            ncnt[k] = 0;
        end
        mptr = 0;
        q.delete();
        last_s = '0; last_c = '0; last_ph = '0; last_ch = 0;
    endtask

    task automatic step();
        smp_t e;
        logic [7:0] a;
        @(posedge clk);
        cyc++;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].due == cyc + 1) begin
                e = q[i];
                a = e.ph[15:8];
                e.s = msin[a];
                e.c = mcos[a];
                q[i] = e;
            end
        end
        if (!csb1) begin
            e.due = cyc + 2; e.ch = mptr; e.ph = macc[mptr]; e.s = '0; e.c = '0;
            q.push_back(e);
        end
        if (!csb0 && !web0) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask0[b]) begin
                    msin[addr0][8*b +: 8] = din00[8*b +: 8];
                    mcos[addr0][8*b +: 8] = din01[8*b +: 8];
                end
            end
        end
        if (!csb1) begin
            if (mup[mptr]) macc[mptr] = macc[mptr] + {8'h00, mdel[mptr]};
            else           macc[mptr] = macc[mptr] - {8'h00, mdel[mptr]};
            mptr = (mptr + 1) % 4;
        end
        if (cfg_we) begin
            mdel[cfg_ch] = cfg_delta;
            mup[cfg_ch]  = cfg_up_dn;
            if (cfg_preload) macc[cfg_ch] = cfg_pl_data;
        end
        #1;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("valid", out_valid, 1);
            chk("ch", out_ch, e.ch);
            chk("phase", phase_out, e.ph);
            chk("sine", sine_out, e.s);
            chk("cosine", cosine_out, e.c);
            last_s = e.s; last_c = e.c; last_ph = e.ph; last_ch = e.ch;
            if (t2_on) begin
                chk("seq_phase", phase_out, 16'(ncnt[e.ch] * (e.ch + 1)));
                ncnt[e.ch]++;
            end
        end else begin
            chk("idle_valid", out_valid, 0);
            chk("hold_phase", phase_out, last_ph);
            chk("hold_sine", sine_out, last_s);
            chk("hold_cos", cosine_out, last_c);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_ch", out_ch, 0);
        chk("rst_phase", phase_out, 0);
        chk("rst_sine", sine_out, 0);
        chk("rst_cos", cosine_out, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic cfg(input int ch, input int dl, input bit up, input bit pl, input logic [15:0] pd);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_delta = 8'(dl); cfg_up_dn = up;
        cfg_preload = pl; cfg_pl_data = pd;
        step();
        cfg_we = 1'b0; cfg_preload = 1'b0;
    endtask

    initial begin
        real r;
        int  sv, cv;
        cyc = 0;
        t2_on = 1'b0;
        #2;
        do_reset();

        for (int i = 0; i < 256; i++) begin
            r  = 3.14159265358979 * i / 128.0;
            sv = int'($sin(r) * 2147483647.0);
            cv = int'($cos(r) * 2147483647.0);
            csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 8'(i);
            din00 = sv; din01 = cv;
            step();
        end
        csb0 = 1'b1; web0 = 1'b1;

        for (int k = 0; k < 4; k++) cfg(k, k + 1, 1'b1, 1'b0, 16'h0);
        t2_on = 1'b1;
        csb1 = 1'b0;
        repeat (3) step();
        chk("t1_ch", out_ch, 0);
        chk("t1_phase", phase_out, 16'h0000);
        chk("t1_sine", sine_out, 32'h0000_0000);
        chk("t1_cos", cosine_out, 32'h7FFF_FFFF);
        repeat (400) step();
        t2_on = 1'b0;

        csb1 = 1'b1;
        repeat (3) step();
        cfg(1, 1, 1'b1, 1'b1, 16'hFFFF);
        cfg(2, 3, 1'b0, 1'b1, 16'h0000);
        csb1 = 1'b0;
        repeat (12) step();

        csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'b0001; addr0 = 8'd5;
        din00 = 32'hFFFF_FFFF; din01 = 32'h1234_5678;
        step();
        csb0 = 1'b1; web0 = 1'b1;
        cfg(0, 0, 1'b1, 1'b1, 16'h0500);
        repeat (10) step();

        for (int n = 0; n < 8 && mptr != 2; n++) step();
        cfg(2, 1, 1'b1, 1'b1, 16'h4000);
        repeat (10) step();

        for (int n = 0; n < 8 && mptr != 3; n++) step();
        csb1 = 1'b1;
        repeat (4) step();
        csb1 = 1'b0;
        repeat (6) step();
        do_reset();
        repeat (12) step();

        repeat (600) begin
            csb1 = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 3) == 0) begin
                csb0 = 1'b0; web0 = $urandom_range(0, 5) == 0;
                wmask0 = 4'($urandom); addr0 = 8'($urandom);
                din00 = $urandom; din01 = $urandom;
            end else begin
                csb0 = $urandom_range(0, 1) == 0; web0 = 1'b1;
            end
            cfg_we = ($urandom_range(0, 4) == 0);
            cfg_ch = 2'($urandom);
            cfg_delta = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
            cfg_up_dn = 1'($urandom);
            cfg_preload = 1'($urandom);
            cfg_pl_data = 16'($urandom);
            step();
        end
        cfg_we = 1'b0; csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
        repeat (3) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
